// File: rtl/model_replay_buffer.sv
// Replay buffer of (location, action, next location, reward) transitions feeding a planning sampler.
// Define REPLAY_RANDOM_EN for LFSR-driven sampling; otherwise entries are sampled in order.
module model_replay_buffer #(
    parameter int LOCATION_LENGTH = 8,
    parameter int REWARD_LENGTH   = 11,
    parameter int DEPTH_LOG2      = 4,
    parameter int PLAN_STEPS      = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       store,
    input  logic [LOCATION_LENGTH-1:0] s_location,
    input  logic [1:0]                 s_action,
    input  logic [LOCATION_LENGTH-1:0] s_n_location,
    input  logic [REWARD_LENGTH-1:0]   s_reward,
    input  logic                       plan_start,
    input  logic                       plan_ready,
    output logic                       plan_valid,
    output logic [LOCATION_LENGTH-1:0] plan_location,
    output logic [1:0]                 plan_action,
    output logic [LOCATION_LENGTH-1:0] plan_n_location,
    output logic [REWARD_LENGTH-1:0]   plan_reward,
    output logic                       plan_busy,
    output logic                       plan_done,
    output logic [DEPTH_LOG2:0]        count
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT  = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE    = DEPTH_LOG2'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] IDX_ZERO   = DEPTH_LOG2'(1'b0);
    localparam logic [7:0]            STEPS_LAST = PLAN_STEPS[7:0];
    localparam logic [15:0]           LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Fibonacci LFSR step, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [LOCATION_LENGTH-1:0] mem_loc_r   [DEPTH];
    logic [1:0]                 mem_act_r   [DEPTH];
    logic [LOCATION_LENGTH-1:0] mem_nloc_r  [DEPTH];
    logic [REWARD_LENGTH-1:0]   mem_rew_r   [DEPTH];

    state_t                     state_r;
    state_t                     next_state_s;
    logic [DEPTH_LOG2-1:0]      wr_ptr_r;
    logic [DEPTH_LOG2:0]        count_r;
    logic [7:0]                 step_r;
    logic [DEPTH_LOG2-1:0]      seq_idx_r;
    logic [DEPTH_LOG2:0]        seq_inc_s;
    logic [15:0]                lfsr_r;
    logic [DEPTH_LOG2-1:0]      cand_idx_s;
    logic                       cand_ok_s;
    logic                       handshake_s;
    logic                       last_step_s;

    logic                       plan_valid_r;
    logic                       plan_busy_r;
    logic                       plan_done_r;
    logic [LOCATION_LENGTH-1:0] plan_loc_r;
    logic [1:0]                 plan_act_r;
    logic [LOCATION_LENGTH-1:0] plan_nloc_r;
    logic [REWARD_LENGTH-1:0]   plan_rew_r;

    // Candidate index selection and handshake decode.
    always_comb begin
`ifdef REPLAY_RANDOM_EN
        cand_idx_s = lfsr_r[DEPTH_LOG2-1:0];
`else
        cand_idx_s = seq_idx_r;
`endif
        cand_ok_s   = ({1'b0, cand_idx_s} < count_r);
        handshake_s = (state_r == ISSUE) && plan_ready;
        last_step_s = ((step_r + 8'd1) == STEPS_LAST);
        seq_inc_s   = {1'b0, seq_idx_r} + CNT_ONE;
    end

    // Next-state logic for the planning burst.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (plan_start) begin
                    if (count_r != '0) begin
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = DONE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                if (cand_ok_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            ISSUE: begin
                if (plan_ready) begin
                    if (last_step_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = FETCH;
                    end
                end else begin
                    next_state_s = ISSUE;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Entry storage; contents survive reset and become unreachable via count.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_loc_r[wr_ptr_r]  <= s_location;
            mem_act_r[wr_ptr_r]  <= s_action;
            mem_nloc_r[wr_ptr_r] <= s_n_location;
            mem_rew_r[wr_ptr_r]  <= s_reward;
        end
    end

    // Write pointer, fill count, step counter, sequential index and LFSR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            wr_ptr_r  <= IDX_ZERO;
            count_r   <= '0;
            step_r    <= 8'd0;
            seq_idx_r <= IDX_ZERO;
            lfsr_r    <= LFSR_SEED;
        end else begin
            state_r <= next_state_s;
            lfsr_r  <= lfsr_next(lfsr_r);
            if (store) begin
                wr_ptr_r <= wr_ptr_r + IDX_ONE;
                if (count_r != DEPTH_CNT) begin
                    count_r <= count_r + CNT_ONE;
                end
            end
            if (handshake_s) begin
                step_r <= step_r + 8'd1;
                // Wrap against the count seen this cycle so the index never points past valid data.
                if (seq_inc_s >= count_r) begin
                    seq_idx_r <= IDX_ZERO;
                end else begin
                    seq_idx_r <= seq_inc_s[DEPTH_LOG2-1:0];
                end
            end else if (state_r == DONE) begin
                step_r <= 8'd0;
            end
        end
    end

    // Registered sample outputs; latched copies are immune to later overwrites.
    always_ff @(posedge clk) begin
        if (reset) begin
            plan_valid_r <= 1'b0;
            plan_busy_r  <= 1'b0;
            plan_done_r  <= 1'b0;
            plan_loc_r   <= '0;
            plan_act_r   <= 2'd0;
            plan_nloc_r  <= '0;
            plan_rew_r   <= '0;
        end else begin
            plan_valid_r <= (next_state_s == ISSUE);
            plan_busy_r  <= (next_state_s != IDLE);
            plan_done_r  <= (state_r == DONE);
            if ((state_r == FETCH) && cand_ok_s) begin
                plan_loc_r  <= mem_loc_r[cand_idx_s];
                plan_act_r  <= mem_act_r[cand_idx_s];
                plan_nloc_r <= mem_nloc_r[cand_idx_s];
                plan_rew_r  <= mem_rew_r[cand_idx_s];
            end
        end
    end

    assign plan_valid      = plan_valid_r;
    assign plan_busy       = plan_busy_r;
    assign plan_done       = plan_done_r;
    assign plan_location   = plan_loc_r;
    assign plan_action     = plan_act_r;
    assign plan_n_location = plan_nloc_r;
    assign plan_reward     = plan_rew_r;
    assign count           = count_r;

endmodule

// File: tb/tb_model_replay_buffer.sv
// Self-checking bench for model_replay_buffer: store table, scoreboard of expected samples,
// and hand sequences for empty burst, wrap-around, stall with overwrite and mid-burst reset.
module tb_model_replay_buffer;

    localparam int LL    = 8;
    localparam int RL    = 11;
    localparam int DL    = 4;
    localparam int PS    = 5;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          store;
    logic [LL-1:0] s_location;
    logic [1:0]    s_action;
    logic [LL-1:0] s_n_location;
    logic [RL-1:0] s_reward;
    logic          plan_start;
    logic          plan_ready;
    logic          plan_valid;
    logic [LL-1:0] plan_location;
    logic [1:0]    plan_action;
    logic [LL-1:0] plan_n_location;
    logic [RL-1:0] plan_reward;
    logic          plan_busy;
    logic          plan_done;
    logic [DL:0]   count;

    always #5 clk = ~clk;

    model_replay_buffer #(
        .LOCATION_LENGTH(LL), .REWARD_LENGTH(RL), .DEPTH_LOG2(DL), .PLAN_STEPS(PS)
    ) dut (
        .clk(clk), .reset(reset), .store(store),
        .s_location(s_location), .s_action(s_action),
        .s_n_location(s_n_location), .s_reward(s_reward),
        .plan_start(plan_start), .plan_ready(plan_ready), .plan_valid(plan_valid),
        .plan_location(plan_location), .plan_action(plan_action),
        .plan_n_location(plan_n_location), .plan_reward(plan_reward),
        .plan_busy(plan_busy), .plan_done(plan_done), .count(count)
    );

    typedef struct {
        logic [LL-1:0] loc;
        logic [1:0]    act;
        logic [LL-1:0] nloc;
        logic [RL-1:0] rew;
    } sample_t;

    typedef struct {
        logic [LL-1:0] loc;
        logic [1:0]    act;
        logic [LL-1:0] nloc;
        logic [RL-1:0] rew;
        int            exp_count;
    } store_vec_t;

    sample_t exp_q[$];
    sample_t mmem[DEPTH];
    int      mcount;
    int      mwr;
    int      mseq;
    bit      stored_seen[256];
    bit      sampled_seen[256];
    int      n_cmp = 0;
    int      n_fail = 0;
    int      done_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mcount = 0;
        mwr    = 0;
        mseq   = 0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            stored_seen[i]  = 1'b0;
            sampled_seen[i] = 1'b0;
        end
    endtask

    task automatic do_store(input logic [LL-1:0] l, input logic [1:0] a,
                            input logic [LL-1:0] n, input logic [RL-1:0] r);
        store        = 1'b1;
        s_location   = l;
        s_action     = a;
        s_n_location = n;
        s_reward     = r;
        tick();
        store = 1'b0;
        mmem[mwr] = '{l, a, n, r};
        mwr = (mwr + 1) % DEPTH;
        if (mcount < DEPTH) mcount++;
        stored_seen[l] = 1'b1;
    endtask

    task automatic start_burst();
`ifndef REPLAY_RANDOM_EN
        if (mcount > 0) begin
            for (int i = 0; i < PS; i++) begin
                exp_q.push_back(mmem[mseq]);
                mseq = (mseq + 1 >= mcount) ? 0 : mseq + 1;
            end
        end
`endif
        plan_start = 1'b1;
        tick();
        plan_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (plan_done) seen = 1'b1;
        end
        check("burst_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; i < limit && !plan_valid; i++) tick();
        check("valid_seen", 32'(plan_valid), 32'd1);
    endtask

    // Scoreboard monitor: compares every handshaken sample, counts done pulses.
    initial begin
        sample_t e;
        forever begin
            @(negedge clk);
            if (!reset && plan_valid && plan_ready) begin
`ifdef REPLAY_RANDOM_EN
                check("rand_loc_stored", 32'(stored_seen[plan_location]), 32'd1);
                sampled_seen[plan_location] = 1'b1;
`else
                if (exp_q.size() == 0) begin
                    check("queue_has_entry", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("smp_loc",  32'(plan_location),   32'(e.loc));
                    check("smp_act",  32'(plan_action),     32'(e.act));
                    check("smp_nloc", 32'(plan_n_location), 32'(e.nloc));
                    check("smp_rew",  32'(plan_reward),     32'(e.rew));
                end
`endif
            end
            if (!reset && plan_done) done_pulses++;
        end
    end

    initial begin
        store_vec_t vec[3];
        sample_t    cap;
        int         d0;

        vec[0] = '{8'd1, 2'd0, 8'd2, 11'd10, 1};
        vec[1] = '{8'd2, 2'd1, 8'd3, 11'd20, 2};
        vec[2] = '{8'd3, 2'd2, 8'd4, 11'd30, 3};

        reset = 1'b1; store = 1'b0; plan_start = 1'b0; plan_ready = 1'b1;
        s_location = '0; s_action = 2'd0; s_n_location = '0; s_reward = '0;
        model_reset();
        repeat (3) tick();
        check("rst_valid", 32'(plan_valid), 32'd0);
        check("rst_done",  32'(plan_done),  32'd0);
        check("rst_busy",  32'(plan_busy),  32'd0);
        check("rst_count", 32'(count),      32'd0);
        check("rst_loc",   32'(plan_location),   32'd0);
        check("rst_act",   32'(plan_action),     32'd0);
        check("rst_nloc",  32'(plan_n_location), 32'd0);
        check("rst_rew",   32'(plan_reward),     32'd0);
        reset = 1'b0;
        tick();

        // Empty buffer: burst ends immediately, done two cycles after the request.
        d0 = done_pulses;
        start_burst();
        check("empty_busy_t1",  32'(plan_busy),  32'd1);
        check("empty_done_t1",  32'(plan_done),  32'd0);
        tick();
        check("empty_done_t2",  32'(plan_done),  32'd1);
        check("empty_valid_t2", 32'(plan_valid), 32'd0);
        tick();
        check("empty_done_t3",  32'(plan_done),  32'd0);
        check("empty_busy_t3",  32'(plan_busy),  32'd0);
        check("empty_pulses",   32'(done_pulses - d0), 32'd1);

        // Table of stores with expected fill count.
        for (int i = 0; i < 3; i++) begin
            do_store(vec[i].loc, vec[i].act, vec[i].nloc, vec[i].rew);
            check("tbl_count", 32'(count), 32'(vec[i].exp_count));
        end

        start_burst();
        check("lat_busy_t1", 32'(plan_busy), 32'd1);
        tick();
`ifndef REPLAY_RANDOM_EN
        check("lat_valid_t2", 32'(plan_valid), 32'd1);
`endif
        wait_done(400);
        check("q_empty_b1", 32'(exp_q.size()), 32'd0);

`ifdef REPLAY_RANDOM_EN
        for (int b = 0; b < 1000; b++) begin
            start_burst();
            wait_done(400);
        end
        check("rand_seen_1", 32'(sampled_seen[1]), 32'd1);
        check("rand_seen_2", 32'(sampled_seen[2]), 32'd1);
        check("rand_seen_3", 32'(sampled_seen[3]), 32'd1);
`else
        // Sequential index persists across bursts: expect 3,1,2,3,1.
        start_burst();
        wait_done(200);
        check("q_empty_b2", 32'(exp_q.size()), 32'd0);
`endif

        // Overfill: 20 stores, oldest four overwritten; bursts read back entries in order.
        reset = 1'b1; tick(); reset = 1'b0; model_reset();
        for (int i = 0; i < 20; i++) begin
            do_store(8'(i), 2'(i % 4), 8'(i + 1), 11'(i * 10));
            check("wrap_count", 32'(count), 32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
        end
        for (int b = 0; b < 4; b++) begin
            start_burst();
            wait_done(400);
        end
        check("q_empty_wrap", 32'(exp_q.size()), 32'd0);

        // Stall with a concurrent overwrite of the entry being issued.
        plan_ready = 1'b0;
        start_burst();
        wait_valid(200);
`ifdef REPLAY_RANDOM_EN
        cap = '{plan_location, plan_action, plan_n_location, plan_reward};
`else
        cap = exp_q[0];
`endif
        for (int i = 0; i < 10; i++) begin
            if (i == 4) do_store(8'd99, 2'd3, 8'd98, 11'd999);
            else tick();
            check("stall_valid", 32'(plan_valid),      32'd1);
            check("stall_loc",   32'(plan_location),   32'(cap.loc));
            check("stall_act",   32'(plan_action),     32'(cap.act));
            check("stall_nloc",  32'(plan_n_location), 32'(cap.nloc));
            check("stall_rew",   32'(plan_reward),     32'(cap.rew));
        end
        plan_ready = 1'b1;
        wait_done(400);
        check("q_empty_stall", 32'(exp_q.size()), 32'd0);
        check("stall_count",   32'(count),        32'd16);

        // Reset while a sample is being issued: burst aborts silently.
        plan_ready = 1'b0;
        start_burst();
        wait_valid(200);
        d0 = done_pulses;
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(plan_valid), 32'd0);
        check("mid_rst_busy",  32'(plan_busy),  32'd0);
        check("mid_rst_count", 32'(count),      32'd0);
        check("mid_rst_done",  32'(plan_done),  32'd0);
        reset = 1'b0;
        model_reset();
        plan_ready = 1'b1;
        repeat (4) tick();
        check("mid_rst_no_done", 32'(done_pulses - d0), 32'd0);
        check("mid_rst_idle",    32'(plan_busy),        32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/model_replay_buffer.md
MODEL_REPLAY_BUFFER -- requirements
Module: model_replay_buffer

Interface
REQ-001 SHALL have parameter LOCATION_LENGTH, default 8: location width.
REQ-002 SHALL have parameter REWARD_LENGTH, default 11: reward width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4: buffer depth DEPTH = 2**DEPTH_LOG2 entries.
REQ-004 SHALL have parameter PLAN_STEPS, default 5, range 1..255: planning samples per burst.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port store, input, 1: one-cycle write strobe for a completed transition.
REQ-008 SHALL have ports s_location (LOCATION_LENGTH), s_action (2), s_n_location (LOCATION_LENGTH) and s_reward (REWARD_LENGTH), all inputs: the transition fields written on store.
REQ-009 SHALL have port plan_start, input, 1: requests one planning burst.
REQ-010 SHALL have port plan_ready, input, 1: consumer accepts the current sample.
REQ-011 SHALL have port plan_valid, output, 1: a sample is presented.
REQ-012 SHALL have ports plan_location, plan_action, plan_n_location and plan_reward, all outputs, widths as the s_ fields: the sample fields.
REQ-013 SHALL have port plan_busy, output, 1: high whenever the FSM is not IDLE.
REQ-014 SHALL have port plan_done, output, 1: one-cycle pulse marking the end of a burst.
REQ-015 SHALL have port count, output, DEPTH_LOG2+1: number of valid entries.

Function
REQ-016 SHALL write the four s_ fields to entry wr_ptr on store, increment wr_ptr modulo DEPTH, and saturate count at DEPTH; when full, the oldest entry is overwritten.
REQ-017 SHALL accept store in every state, including during a burst.
REQ-018 SHALL implement FSM states IDLE, FETCH, ISSUE and DONE.
REQ-019 SHALL, in IDLE, go to FETCH on plan_start when count>0, and go to DONE when count==0; the decision uses count before any same-cycle store.
REQ-020 SHALL ignore plan_start in any state other than IDLE.
REQ-021 SHALL, in FETCH, form a candidate index; when the index is < count, it latches that entry into the plan_ registers and goes to ISSUE; otherwise it stays in FETCH.
REQ-022 SHALL, in ISSUE, hold plan_valid=1 and keep the plan_ fields stable until plan_ready=1.
REQ-023 SHALL, on an ISSUE handshake, increment the step counter, then go to DONE when the count reaches PLAN_STEPS, else to FETCH.
REQ-024 SHALL, in DONE, assert plan_done for exactly one cycle, clear the step counter and return to IDLE.
REQ-025 SHALL give latency plan_start(t) -> FETCH(t+1) -> plan_valid at t+2 at the earliest.
REQ-026 SHALL keep the plan_ outputs at their latched values when a store overwrites the entry being issued.
REQ-027 SHALL include a 16-bit Fibonacci LFSR with taps 16,14,13,11 that advances every cycle.

Reset
REQ-028 SHALL, on reset, drive plan_valid=0, plan_done=0, plan_busy=0, all plan_ fields=0, count=0, wr_ptr=0, step counter=0, sequential index=0, LFSR=16'hACE1, FSM=IDLE.
REQ-029 SHALL, on reset mid-burst, abort the burst without any plan_done pulse; entry contents are not cleared but are unreachable until rewritten.

Configuration
REQ-030 SHALL, with macro REPLAY_RANDOM_EN defined, use LFSR[DEPTH_LOG2-1:0] as the FETCH candidate index, retrying while the index is >= count.
REQ-031 SHALL, with REPLAY_RANDOM_EN undefined, use a sequential index as the FETCH candidate: start at 0, increment on each handshake, wrap to 0 at count, and persist across bursts; FETCH then always takes exactly 1 cycle.

Verification
REQ-032 SHALL cover: reset, then plan_start with count=0 -> plan_done pulse at t+2, plan_valid never asserted.
REQ-033 SHALL cover: 3 stores (loc 1/2/3, action 0/1/2, n_loc 2/3/4, reward 10/20/30), random mode undefined, plan_start with plan_ready=1 -> 5 samples with loc 1,2,3,1,2, then plan_done.
REQ-034 SHALL cover: 20 stores with loc 0..19 -> count=16, entries hold loc 4..19, entry 0 holds loc 16.
REQ-035 SHALL cover: plan_ready held 0 for 10 cycles during ISSUE -> plan_valid and fields stable throughout; a concurrent store to the issued entry leaves the outputs unchanged.
REQ-036 SHALL cover: REPLAY_RANDOM_EN defined, count=3, 1000 bursts -> every sampled location is one of the stored values and all 3 occur.
REQ-037 SHALL cover: reset asserted during ISSUE -> the next cycle shows plan_valid=0, plan_busy=0, count=0, and no plan_done.
